// File: rtl/keyboard_scanner_n_if.sv
// Event output handshake: FIFO head presented with valid/ready.
interface keyboard_scanner_n_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg;

  modport master (output msg_valid, output msg, input msg_ready);
  modport slave  (input msg_valid, input msg, output msg_ready);
endinterface

// File: rtl/keyboard_scanner_n.sv
// Round-robin piano key scanner: per-key debounce, note-on/off events with
// octave shift remembered per held key, FWFT event FIFO on valid/ready.

// One key's debounce state plus the shift captured when it was pressed.
module keyboard_scanner_n_lane #(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int RESET_SHIFT    = 4
) (
  input  logic       clk_scan_13x,
  input  logic       rst,
  input  logic       en,
  input  logic       raw,
  input  logic [3:0] cur_shift,
  output logic       commit,
  output logic [3:0] sh
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic          stable;
  logic [CW-1:0] cnt;

  // Commit fires on the visit that completes the run of differing samples.
  always_comb begin
    commit = en && (raw != stable) && (cnt == CW'(DEBOUNCE_SCANS - 1));
  end

  // Debounce counter and committed level; only advance when scanned.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      stable <= 1'b1;
      cnt    <= '0;
      sh     <= 4'(RESET_SHIFT);
    end else if (en) begin
      if (raw == stable) begin
        cnt <= '0;
      end else if (commit) begin
        stable <= raw;
        cnt    <= '0;
        if (!raw) sh <= cur_shift;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module keyboard_scanner_n #(
  parameter int NUM_KEYS       = 13,
  parameter int MIN_SHIFT      = 3,
  parameter int MAX_SHIFT      = 6,
  parameter int RESET_SHIFT    = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk_scan_13x,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key,
  input  logic [1:0]                    pitch,
  keyboard_scanner_n_if.master          msg_if,
  output logic [3:0]                    shift_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int IW = $clog2(NUM_KEYS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_KEYS - 1);

  logic [IW-1:0]              idx;
  logic [3:0]                 shift;
  logic [1:0]                 pitch_q;
  logic [NUM_KEYS-1:0]        en;
  logic [NUM_KEYS-1:0]        commit;
  logic [NUM_KEYS-1:0][3:0]   sh;

  // Scan-slot decode: exactly one lane is enabled per clock.
  always_comb begin
    en = '0;
    en[idx] = 1'b1;
  end

  keyboard_scanner_n_lane #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .RESET_SHIFT    (RESET_SHIFT)
  ) u_lane [NUM_KEYS-1:0] (
    .clk_scan_13x (clk_scan_13x),
    .rst          (rst),
    .en           (en),
    .raw          (key),
    .cur_shift    (shift),
    .commit       (commit),
    .sh           (sh)
  );

  // Event build for the scanned key; releases use the press-time shift.
  logic       hit, press, push;
  logic [3:0] ev_sh;
  logic [8:0] note9;
  logic [7:0] ev_msg;
  always_comb begin
    hit    = |commit;
    press  = ~key[idx];
    ev_sh  = press ? shift : sh[idx];
    note9  = (9'(ev_sh) + 9'd1) * 9'd12 + 9'(idx);
    push   = hit && (note9 <= 9'd127);
    ev_msg = {press, note9[6:0]};
  end

  // Scan index and once-per-sweep pitch button edge detection.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      shift   <= 4'(RESET_SHIFT);
      pitch_q <= 2'b11;
    end else begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if (idx == LAST) begin
        pitch_q <= pitch;
        if (pitch_q[0] && !pitch[0] && !(pitch_q[1] && !pitch[1]) &&
            shift > 4'(MIN_SHIFT))
          shift <= shift - 1'b1;
        else if (pitch_q[1] && !pitch[1] && !(pitch_q[0] && !pitch[0]) &&
                 shift < 4'(MAX_SHIFT))
          shift <= shift + 1'b1;
      end
    end
  end

  // Event FIFO: a full FIFO still accepts a push when the head pops.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, wr;
  always_comb begin
    full = (level == LW'(FIFO_DEPTH));
    pop  = (level != '0) && msg_if.msg_ready;
    wr   = push && (!full || pop);
  end

  // Storage needs no reset; the output is gated by valid.
  always_ff @(posedge clk_scan_13x) begin
    if (wr) mem[wr_ptr] <= ev_msg;
  end

  // Pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk_scan_13x or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      level <= level + 1'b1;
      else if (!wr && pop) level <= level - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign msg_if.msg_valid = (level != '0);
  assign msg_if.msg       = (level != '0) ? mem[rd_ptr] : 8'h00;
  assign shift_out        = shift;
  assign fifo_level       = level;
endmodule

// File: tb/tb_keyboard_scanner_n.sv
// Directed scoreboard bench for keyboard_scanner_n (default parameters).
module tb_keyboard_scanner_n;
  localparam int N = 13;

  logic          clk_scan_13x = 1'b0;
  logic          rst;
  logic [N-1:0]  key;
  logic [1:0]    pitch;
  logic [3:0]    shift_out;
  logic [3:0]    fifo_level;
  logic          overflow;

  keyboard_scanner_n_if msg_if();

  keyboard_scanner_n #(
    .NUM_KEYS(N), .MIN_SHIFT(3), .MAX_SHIFT(6), .RESET_SHIFT(4),
    .DEBOUNCE_SCANS(3), .FIFO_DEPTH(8)
  ) dut (
    .clk_scan_13x (clk_scan_13x),
    .rst          (rst),
    .key          (key),
    .pitch        (pitch),
    .msg_if       (msg_if),
    .shift_out    (shift_out),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk_scan_13x = ~clk_scan_13x;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  int         m_idx;

  // Bench-side scan phase, used only to align stimulus with key 0.
  always @(posedge clk_scan_13x or posedge rst) begin
    if (rst) m_idx <= 0;
    else     m_idx <= (m_idx == N - 1) ? 0 : m_idx + 1;
  end

  // Monitor: every accepted event must match the scoreboard head.
  always @(negedge clk_scan_13x) begin
    if (!rst && msg_if.msg_valid && msg_if.msg_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL msg_unexpected got=%02h want=none", msg_if.msg);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (msg_if.msg !== e) begin
          bad++;
          $display("FAIL msg_order got=%02h want=%02h", msg_if.msg, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_scan_13x);
    #1;
  endtask

  task automatic align0();
    cyc(1);
    for (int i = 0; i < 2 * N && m_idx != 0; i++) cyc(1);
  endtask

  task automatic pulse_pitch(input logic [1:0] p);
    pitch = p;
    cyc(N);
    pitch = 2'b11;
    cyc(N);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int up_exp [4];
    int dn_exp [4];
    up_exp = '{5, 6, 6, 6};
    dn_exp = '{5, 4, 3, 3};

    key = '1; pitch = 2'b11; msg_if.msg_ready = 1'b1; rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_valid",    msg_if.msg_valid, 0);
    chk("rst_msg",      msg_if.msg, 0);
    chk("rst_level",    fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_shift",    shift_out, 4);

    // Clean press/release of key 0.
    align0();
    exp_q.push_back(8'hBC);
    key[0] = 1'b0;
    cyc(3 * N);
    drain("press_k0");
    exp_q.push_back(8'h3C);
    key[0] = 1'b1;
    cyc(3 * N);
    drain("release_k0");

    // Bounce: two visits low must not commit; three must.
    key[5] = 1'b0; cyc(2 * N);
    key[5] = 1'b1; cyc(2 * N);
    chk("bounce_level", fifo_level, 0);
    msg_if.msg_ready = 1'b0;
    key[5] = 1'b0; cyc(2 * N);
    chk("bounce_two_visits", fifo_level, 0);
    cyc(N);
    chk("bounce_three_visits", fifo_level, 1);
    exp_q.push_back(8'hC1);
    msg_if.msg_ready = 1'b1;
    drain("press_k5");
    exp_q.push_back(8'h41);
    key[5] = 1'b1; cyc(3 * N);
    drain("release_k5");

    // Release uses the press-time shift.
    exp_q.push_back(8'hBE);
    key[2] = 1'b0; cyc(3 * N);
    drain("press_k2_s4");
    pulse_pitch(2'b01);
    chk("shift_up_once", shift_out, 5);
    exp_q.push_back(8'h3E);
    key[2] = 1'b1; cyc(3 * N);
    drain("release_k2_stored");
    exp_q.push_back(8'hCA);
    key[2] = 1'b0; cyc(3 * N);
    drain("press_k2_s5");
    exp_q.push_back(8'h4A);
    key[2] = 1'b1; cyc(3 * N);
    drain("release_k2_s5");

    // Shift limits.
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    chk("shift_after_rst", shift_out, 4);
    for (int i = 0; i < 4; i++) begin
      pulse_pitch(2'b01);
      chk($sformatf("shift_up_%0d", i), shift_out, up_exp[i]);
    end
    pulse_pitch(2'b00);
    chk("shift_both", shift_out, 6);
    for (int i = 0; i < 4; i++) begin
      pulse_pitch(2'b10);
      chk($sformatf("shift_dn_%0d", i), shift_out, dn_exp[i]);
    end
    pulse_pitch(2'b01);
    chk("shift_back_4", shift_out, 4);

    // Overflow and backpressure: keys 0..8 commit in one sweep.
    msg_if.msg_ready = 1'b0;
    align0();
    key[8:0] = '0;
    cyc(3 * N);
    chk("ovf_level",    fifo_level, 8);
    chk("ovf_flag",     overflow, 1);
    chk("ovf_valid",    msg_if.msg_valid, 1);
    chk("ovf_head",     msg_if.msg, 8'hBC);
    cyc(5);
    chk("ovf_head_hold", msg_if.msg, 8'hBC);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hBC + 8'(i));
    msg_if.msg_ready = 1'b1;
    drain("ovf_drain");
    cyc(1);
    chk("ovf_empty_valid", msg_if.msg_valid, 0);
    align0();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h3C + 8'(i));
    key[8:0] = '1;
    cyc(3 * N);
    drain("ovf_release");
    chk("ovf_sticky", overflow, 1);

    // Reset mid-operation with queued events and key 1 held.
    pulse_pitch(2'b01);
    chk("pre_rst_shift", shift_out, 5);
    msg_if.msg_ready = 1'b0;
    align0();
    key[1] = 1'b0; key[3] = 1'b0; key[4] = 1'b0;
    cyc(3 * N);
    chk("pre_rst_level", fifo_level, 3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; key[3] = 1'b1; key[4] = 1'b1;
    #1;
    chk("mid_rst_valid",    msg_if.msg_valid, 0);
    chk("mid_rst_level",    fifo_level, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_shift",    shift_out, 4);
    msg_if.msg_ready = 1'b1;
    exp_q.push_back(8'hBD);
    cyc(3 * N);
    drain("post_rst_k1");
    exp_q.push_back(8'h3D);
    key[1] = 1'b1;
    cyc(3 * N);
    drain("post_rst_k1_rel");

    cyc(N);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keyboard_scanner_n.md
Name: keyboard_scanner_n

Overview:
- Parametrised successor to the 13-key piano keyboard scanner.
- Scans NUM_KEYS active-low piano keys round-robin, one key per clock, in the clk_scan_13x domain.
- Debounces each key and generates MIDI-style note-on/off events.
- Queues events in a FIFO and presents them on a valid/ready handshake instead of a strobe clock.
- Tracks an octave shift from two active-low pitch buttons. Each held key remembers its press-time shift, so note-off always matches the note-on.

Parameters:
- NUM_KEYS, 13: number of key inputs (2..32).
- MIN_SHIFT, 3: lowest octave shift.
- MAX_SHIFT, 6: highest octave shift.
- RESET_SHIFT, 4: shift after reset; MIN_SHIFT <= RESET_SHIFT <= MAX_SHIFT.
- DEBOUNCE_SCANS, 3: consecutive visits with a differing raw level needed to commit a key change (>=1).
- FIFO_DEPTH, 8: event FIFO depth; power of two, >=2.

Ports:
- clk_scan_13x  in  1  scan clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- key  in  NUM_KEYS  raw key levels, active-low (0 = pressed).
- pitch  in  2  [0] = octave down, [1] = octave up; active-low buttons.
- msg_ready  in  1  consumer accepts msg this cycle.
- msg_valid  out  1  FIFO head valid.
- msg  out  8  [7] = 1 note-on / 0 note-off; [6:0] = MIDI note.
- shift_out  out  4  current octave shift.
- fifo_level  out  clog2(FIFO_DEPTH)+1  queued event count.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- **Reset** (async, rst=1):
  - scan index = 0; all stable states = 1 (released); debounce counters = 0; per-key stored shift = RESET_SHIFT.
  - shift = RESET_SHIFT; pitch last-sample = 2'b11.
  - FIFO emptied; msg_valid = 0, msg = 0, fifo_level = 0, overflow = 0.
  - Reset mid-operation discards queued events; no note-offs are generated for keys held at reset.
- **Scan:**
  - Index idx visits keys 0..NUM_KEYS-1, +1 per clock, wrapping to 0 after NUM_KEYS-1.
  - One full sweep = NUM_KEYS clocks.
- **Debounce, per visit of key i:**
  - If key[i] == stable[i]: cnt[i] = 0.
  - Otherwise, if cnt[i] == DEBOUNCE_SCANS-1: commit — stable[i] = key[i], cnt[i] = 0, emit an event.
  - Otherwise: cnt[i] += 1.
  - DEBOUNCE_SCANS = 1 gives immediate commit.
- **Event contents:**
  - Press commit (stable 1->0): store sh[i] = current shift; note = (shift+1)*12 + i; msg[7] = 1.
  - Release commit: note = (sh[i]+1)*12 + i using the stored shift; msg[7] = 0.
  - Note arithmetic uses 9 bits. If the note exceeds 127, the event is discarded, but stable[i] still updates.
- **Pitch buttons:**
  - Sampled only on the clock where idx == NUM_KEYS-1 (once per sweep).
  - Falling edge on pitch[0] with shift > MIN_SHIFT: shift -1.
  - Falling edge on pitch[1] with shift < MAX_SHIFT: shift +1.
  - Both edges in the same sample: no change.
  - Last-sample is updated on every sample.
  - A new shift affects only presses committed after the update clock.
- **FIFO:**
  - First-word-fall-through.
  - Push occurs on the commit clock; msg_valid rises the following clock if the FIFO was empty (no bypass).
  - Pop when msg_valid && msg_ready.
  - Push while full with no pop: event dropped, overflow = 1 until reset.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Pop while empty: ignored.
  - msg holds its value while msg_valid && !msg_ready.
- **Ordering:** events leave in commit order.

Test Plan:
- **Clean press/release:** default params; key[0] = 0 held 3 sweeps -> one msg 0xBC (note 60, on). Then key[0] = 1 held 3 sweeps -> msg 0x3C. No other events; msg_ready = 1.
- **Bounce rejection:** key[5] low for exactly 2 visits then high -> no event, cnt returns to 0. Low for 3 visits -> msg 0xC1 (note 65).
- **Shift tracking:** press key[2] -> 0xBE. Pulse pitch[1] low for one sweep -> shift_out = 5. Release key[2] -> 0x3E (stored shift, not 0x4A). Press key[2] again -> 0xCA.
- **Shift limits:** four up pulses from reset -> shift_out 5, 6, 6, 6. Pitch[0] and pitch[1] falling on the same sample -> unchanged.
- **Overflow and backpressure:** msg_ready = 0; commit 9 events -> fifo_level = 8, overflow = 1, msg stable at first event. Raise msg_ready -> the first 8 events drain in order, msg_valid falls after the 8th.
- **Reset mid-operation:** with 3 queued events and key[1] held, assert rst for 1 cycle -> msg_valid = 0, fifo_level = 0, overflow = 0, shift_out = 4. Key[1] still low afterwards -> fresh 0xBD after 3 sweeps.
